seq_loss_scanner: RTL

Read-side companion to the 1-bit × 65536 receive-flag RAM in the Ethernet receive path. The receiver sets bit `seq` when frame `seq` arrives; this block walks a window of that RAM, counts the zero entries (lost frames) and reports the first lost sequence number. It can optionally clear each entry as it passes, so the window can be reused. It owns the RAM's single port while busy, at a throughput of one entry per clock.

---
 rtl/eth_rx_pkg.sv | 17 +
 rtl/seq_loss_scanner.sv | 107 ++++++++++
 2 files changed

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive path: sequence width, the
// loss-scanner state encoding and its power-on clear policy.
package eth_rx_pkg;

  localparam int SEQ_W = 16;

  // Scans leave the receive-flag RAM untouched unless a caller asks otherwise.
  localparam logic CLEAR_EN_DEFAULT = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } scan_state_t;

endpackage

// File: rtl/seq_loss_scanner.sv
// Walks a window of the 1-bit receive-flag RAM, one entry per clock, counting
// zero entries (lost frames) and capturing the first lost sequence number.
module seq_loss_scanner
  import eth_rx_pkg::*;
#(
  parameter int ADDR_W = SEQ_W,
  parameter int CNT_W  = SEQ_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_seq,
  input  logic [CNT_W-1:0]  length,
  input  logic              clear_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  lost_count,
  output logic [ADDR_W-1:0] first_lost,
  output logic              first_lost_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_din,
  input  logic              mem_dout
);

  localparam logic [CNT_W-1:0] WIN_MAX = CNT_W'(1) << ADDR_W;

  scan_state_t       state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  len_sat;
  logic              clear_q;
  logic              tag_valid;
  logic [ADDR_W-1:0] tag_addr;
  logic              accept;
  logic              last_issue;
  logic              hit;

  assign len_sat    = (length > WIN_MAX) ? WIN_MAX : length;
  assign accept     = (state == ST_IDLE) && start && !abort;
  assign last_issue = (state == ST_ISSUE) && (remaining == CNT_W'(1));
  // Data landing in an abort cycle belongs to a discarded scan.
  assign hit        = tag_valid && !mem_dout && !abort;
  assign mem_din    = 1'b0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE) && !abort;
    mem_we    = (state == ST_ISSUE) && clear_q && !abort;

    unique case (state)
      ST_IDLE:  if (accept) state_nxt = (len_sat == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (last_issue) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      mem_addr         <= '0;
      remaining        <= '0;
      clear_q          <= CLEAR_EN_DEFAULT;
      tag_valid        <= 1'b0;
      tag_addr         <= '0;
      lost_count       <= '0;
      first_lost       <= '0;
      first_lost_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // pre-edge values, independent of statement order.
      state     <= state_nxt;
      tag_valid <= (state == ST_ISSUE) && !abort;
      tag_addr  <= mem_addr;

      // The address stays on the last entry once the window is exhausted.
      if (accept) begin
        mem_addr  <= base_seq;
        remaining <= len_sat;
        clear_q   <= clear_en;
      end else if ((state == ST_ISSUE) && !abort && !last_issue) begin
        mem_addr  <= mem_addr + ADDR_W'(1);
        remaining <= remaining - CNT_W'(1);
      end

      if (accept) begin
        lost_count       <= '0;
        first_lost       <= '0;
        first_lost_valid <= 1'b0;
      end else if (hit) begin
        lost_count <= lost_count + CNT_W'(1);
        if (!first_lost_valid) begin
          first_lost       <= tag_addr;
          first_lost_valid <= 1'b1;
        end
      end
    end
  end

endmodule
